// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI read-channel constants and fetch FSM state type
//
// Purpose: shared constants for the single-beat AXI4 read used by the
// instruction-fetch bridge, plus the fetch state machine encoding.
// Ports: none (package).

package axi_pkg;

  localparam logic [7:0] LEN_SINGLE = 8'd0;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  // Instruction access, secure, unprivileged.
  localparam logic [2:0] PROT_INSTR = 3'b100;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } fetch_state_e;

  // SLVERR and DECERR both have bit 1 set; OKAY and EXOKAY do not.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi_ifetch_bridge.sv
// rtl/axi_ifetch_bridge.sv - IFU to AXI4 read-only instruction fetch bridge
//
// Purpose: issues one single-beat AXI read per fetch at the IFU pc, selects
// the 32-bit instruction lane from the 64-bit read data and pulses
// instr_valid for one cycle when a new instruction is presented.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   pc                 - fetch address from the IFU
//   instr, instr_valid - fetched instruction (held) and its one-cycle strobe
//   AR*                - AXI read address channel (master side)
//   R*                 - AXI read data channel (master side)

module axi_ifetch_bridge
  import axi_pkg::*;
#(
  parameter logic [3:0]  AXI_ID    = 4'h0,
  parameter logic [31:0] ERR_INSTR = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [3:0]  ARID,
  output logic [63:0] ARADDR,
  output logic [7:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic [2:0]  ARPORT,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [63:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RVALID,
  output logic        RREADY
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [63:0]  addr_q;
  logic [31:0]  instr_q;
  logic         valid_q;
  logic         ar_hs;
  logic         r_hs;
  logic [31:0]  lane_data;

  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = RVALID && RREADY;

  // addr_q[2] selects which 32-bit half of the 64-bit beat holds the word.
  assign lane_data = addr_q[2] ? RDATA[63:32] : RDATA[31:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ:  if (ar_hs) state_d = ST_WAIT;
      ST_WAIT: if (r_hs)  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= 64'h0;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Strobe is registered alongside the state so it is high exactly
      // while the FSM sits in DONE.
      valid_q <= (state_d == ST_DONE);
      // pc is only sampled in IDLE, one cycle after instr_valid, so the IFU
      // has the DONE cycle to advance it.
      if (state_q == ST_IDLE) begin
        addr_q <= pc;
      end
      if (r_hs) begin
        instr_q <= resp_is_error(RRESP) ? ERR_INSTR : lane_data;
      end
    end
  end

  assign ARVALID     = (state_q == ST_REQ);
  assign RREADY      = (state_q == ST_WAIT);
  assign ARADDR      = addr_q;
  assign ARID        = AXI_ID;
  assign ARLEN       = LEN_SINGLE;
  assign ARSIZE      = SIZE_4B;
  assign ARBURST     = BURST_INCR;
  assign ARPORT      = PROT_INSTR;
  assign instr       = instr_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_axi_ifetch_bridge.sv
// tb/tb_axi_ifetch_bridge.sv - self-checking bench for axi_ifetch_bridge

module tb_axi_ifetch_bridge;

  logic        clk;
  logic        rst;
  logic [63:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [3:0]  ARID;
  logic [63:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [2:0]  ARPORT;
  logic        ARVALID;
  logic        ARREADY;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  axi_ifetch_bridge dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARPORT(ARPORT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every instr_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && instr_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected_pulse: instr=%h with no fetch outstanding", instr);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (instr !== e) begin
          errors++;
          $display("FAIL scoreboard_instr: got %h expected %h", instr, e);
        end
      end
    end
  end

  // Starts in the negedge of a cycle whose FSM state is IDLE; returns at the
  // negedge of the cycle where instr_valid is seen (lat = cycles after IDLE).
  task automatic run_fetch(input logic [63:0] pc_val, input logic [63:0] rdata_val,
                           input logic [1:0] rresp_val, input int ar_delay, input int r_delay,
                           output int lat, output int first_ar, output logic [63:0] addr_seen,
                           output logic stable, output int valid_cyc);
    int   ar_cnt;
    int   r_cnt;
    bit   seen_ar;
    bit   ar_done;
    bit   done;
    pc = pc_val; RDATA = rdata_val; RRESP = rresp_val;
    ARREADY = 1'b0; RVALID = 1'b0;
    lat = -1; first_ar = -1; addr_seen = 64'h0; stable = 1'b1; valid_cyc = -1;
    ar_cnt = 0; r_cnt = 0; seen_ar = 0; ar_done = 0; done = 0;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        lat = k; valid_cyc = cyc; done = 1;
        ARREADY = 1'b0; RVALID = 1'b0;
      end else begin
        if (ARVALID === 1'b1) begin
          if (!seen_ar) begin
            addr_seen = ARADDR; first_ar = k; seen_ar = 1;
          end else if (ARADDR !== addr_seen) begin
            stable = 1'b0;
          end
          ARREADY = (ar_cnt == ar_delay);
          if (ARREADY) ar_done = 1;
          ar_cnt++;
        end else begin
          if (seen_ar && !ar_done) stable = 1'b0;
          ARREADY = 1'b0;
        end
        if (RREADY === 1'b1) begin
          RVALID = (r_cnt == r_delay);
          r_cnt++;
        end else begin
          RVALID = 1'b0;
        end
      end
    end
  endtask

  task automatic to_idle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = 64'h8000_0000; ARREADY = 1'b1; RVALID = 1'b1;
    RDATA = 64'hAAAA_BBBB_0000_0413; RRESP = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ARVALID !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b expected 0", ARVALID); end
    checks++; if (RREADY !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b expected 0", RREADY); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    checks++; if (ARADDR !== 64'h0) begin errors++; $display("FAIL reset_araddr: got %h expected 0", ARADDR); end
    checks++;
    if (ARID !== 4'h0 || ARLEN !== 8'd0 || ARSIZE !== 3'b010 || ARBURST !== 2'b01 || ARPORT !== 3'b100) begin
      errors++;
      $display("FAIL ar_constants: got id=%h len=%h size=%b burst=%b prot=%b expected 0/00/010/01/100",
               ARID, ARLEN, ARSIZE, ARBURST, ARPORT);
    end
  endtask

  task automatic test_first_fetch();
    int lat, far, vc; logic [63:0] a; logic st;
    rst = 1'b0;
    exp_q.push_back(32'h0000_0413);
    run_fetch(64'h8000_0000, 64'hAAAA_BBBB_0000_0413, 2'b00, 0, 0, lat, far, a, st, vc);
    checks++; if (far != 1) begin errors++; $display("FAIL first_arvalid_cycle: got %0d expected 1", far); end
    checks++; if (a !== 64'h8000_0000) begin errors++; $display("FAIL first_araddr: got %h expected 80000000", a); end
    checks++; if (lat != 3) begin errors++; $display("FAIL first_latency: got %0d expected 3", lat); end
    checks++; if (instr !== 32'h0000_0413) begin errors++; $display("FAIL first_instr: got %h expected 00000413", instr); end
  endtask

  task automatic test_upper_lane();
    int lat, far, vc; logic [63:0] a; logic st;
    to_idle();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b expected 0", instr_valid); end
    checks++; if (instr !== 32'h0000_0413) begin errors++; $display("FAIL instr_held: got %h expected 00000413", instr); end
    exp_q.push_back(32'h0010_0093);
    run_fetch(64'h8000_0004, 64'h0010_0093_0000_0013, 2'b00, 0, 0, lat, far, a, st, vc);
    checks++; if (a !== 64'h8000_0004) begin errors++; $display("FAIL upper_araddr: got %h expected 80000004", a); end
    checks++; if (lat != 3) begin errors++; $display("FAIL upper_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_ar_stall();
    int lat, far, vc; logic [63:0] a; logic st;
    to_idle();
    exp_q.push_back(32'h3333_4444);
    run_fetch(64'h8000_0008, 64'h1111_2222_3333_4444, 2'b00, 5, 0, lat, far, a, st, vc);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL ar_stall_stable: got %b expected 1", st); end
    checks++; if (a !== 64'h8000_0008) begin errors++; $display("FAIL ar_stall_araddr: got %h expected 80000008", a); end
    checks++; if (lat != 8) begin errors++; $display("FAIL ar_stall_latency: got %0d expected 8", lat); end
  endtask

  task automatic test_r_stall();
    int lat, far, vc; logic [63:0] a; logic st;
    to_idle();
    exp_q.push_back(32'h5555_6666);
    // Low address bits pass through untouched; bit 2 still picks the lane.
    run_fetch(64'h8000_0016, 64'h5555_6666_7777_8888, 2'b01, 0, 2, lat, far, a, st, vc);
    checks++; if (a !== 64'h8000_0016) begin errors++; $display("FAIL r_stall_araddr: got %h expected 80000016", a); end
    checks++; if (lat != 5) begin errors++; $display("FAIL r_stall_latency: got %0d expected 5", lat); end
  endtask

  task automatic test_error_resp();
    int lat, far, vc; logic [63:0] a; logic st;
    logic [1:0] resps [2];
    resps[0] = 2'b10; resps[1] = 2'b11;
    for (int i = 0; i < 2; i++) begin
      to_idle();
      exp_q.push_back(EBREAK);
      run_fetch(64'h8000_0020 + 64'(i * 4), 64'hDEAD_BEEF_CAFE_F00D, resps[i], 0, 0, lat, far, a, st, vc);
      checks++; if (instr !== EBREAK) begin errors++; $display("FAIL err_instr[%0d]: got %h expected %h", i, instr, EBREAK); end
      checks++; if (lat != 3) begin errors++; $display("FAIL err_latency[%0d]: got %0d expected 3", i, lat); end
    end
    to_idle();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL err_single_pulse: got %b expected 0", instr_valid); end
  endtask

  task automatic test_back_to_back();
    int lat, far, vc, prev_vc; logic [63:0] a; logic st;
    logic [63:0] p;
    logic [63:0] d;
    logic [31:0] e;
    p = 64'h8000_1000;
    prev_vc = -1;
    for (int i = 0; i < 6; i++) begin
      d = {32'hC000_0000 + 32'(i), 32'h0A00_0000 + 32'(i)};
      e = p[2] ? d[63:32] : d[31:0];
      exp_q.push_back(e);
      run_fetch(p, d, 2'b00, 0, 0, lat, far, a, st, vc);
      checks++; if (a !== p) begin errors++; $display("FAIL b2b_araddr[%0d]: got %h expected %h", i, a, p); end
      checks++; if (lat != 3) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected 3", i, lat); end
      if (i > 0) begin
        checks++;
        if (vc - prev_vc != 4) begin errors++; $display("FAIL b2b_period[%0d]: got %0d expected 4", i, vc - prev_vc); end
      end
      prev_vc = vc;
      // IFU advances pc during the instr_valid cycle.
      p = p + 64'd4;
      pc = p;
      to_idle();
    end
  endtask

  task automatic test_reset_mid();
    int lat, far, vc; logic [63:0] a; logic st;
    pc = 64'h9000_0000; ARREADY = 1'b0; RVALID = 1'b0;
    to_idle();
    ARREADY = 1'b1;
    to_idle();
    checks++; if (RREADY !== 1'b1) begin errors++; $display("FAIL mid_in_wait: got rready=%b expected 1", RREADY); end
    ARREADY = 1'b0;
    rst = 1'b1;
    to_idle();
    checks++;
    if (ARVALID !== 1'b0 || RREADY !== 1'b0 || instr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got arvalid=%b rready=%b instr=%h valid=%b expected 0/0/0/0",
               ARVALID, RREADY, instr, instr_valid);
    end
    rst = 1'b0;
    exp_q.push_back(32'h1234_5678);
    run_fetch(64'h9000_0040, 64'hFFFF_FFFF_1234_5678, 2'b00, 0, 0, lat, far, a, st, vc);
    checks++; if (a !== 64'h9000_0040) begin errors++; $display("FAIL mid_restart_araddr: got %h expected 90000040", a); end
    checks++; if (lat != 3) begin errors++; $display("FAIL mid_restart_latency: got %0d expected 3", lat); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_upper_lane();
    test_ar_stall();
    test_r_stall();
    test_error_resp();
    test_back_to_back();
    test_reset_mid();
    to_idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
